cardinal_nic: RTL and testbench

- Network interface controller that sits directly downstream of the cardinal processor's data-memory port.
- Bridges the processor's load/store path (64-bit data, enable, write-enable) to a cardinal ring/mesh router's input and output channels.
- Exposes four memory-mapped registers: one receive buffer, one transmit buffer and a status register for each.
- Each buffer is a single 64-bit entry with a full flag; software polls the status registers.

---
 rtl/cardinal_nic.sv | 98 +++++++++
 tb/tb_cardinal_nic.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cardinal_nic.sv
// Network interface between the processor data-memory port and a cardinal router.
// One-entry rx and tx buffers with full flags, polled through memory-mapped status registers.
module cardinal_nic #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [0:ADDR_WIDTH-1] addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);

  localparam logic [0:ADDR_WIDTH-1] ADDR_RX_BUF  = ADDR_WIDTH'(0);
  localparam logic [0:ADDR_WIDTH-1] ADDR_RX_STAT = ADDR_WIDTH'(1);
  localparam logic [0:ADDR_WIDTH-1] ADDR_TX_BUF  = ADDR_WIDTH'(2);
  localparam logic [0:ADDR_WIDTH-1] ADDR_TX_STAT = ADDR_WIDTH'(3);

  logic [0:DATA_WIDTH-1] rx_buf_q, rx_buf_d;
  logic [0:DATA_WIDTH-1] tx_buf_q, tx_buf_d;
  logic                  rx_full_q, rx_full_d;
  logic                  tx_full_q, tx_full_d;

  logic rd_en;
  logic wr_en;

  assign rd_en = nicEn & ~nicWrEn;
  assign wr_en = nicEn & nicWrEn;

  // Router-facing handshakes; tx_buf[0] selects the virtual channel.
  assign net_ri = ~rx_full_q;
  assign net_do = tx_buf_q;
  assign net_so = tx_full_q & net_ro & (tx_buf_q[0] == net_polarity);

  // Zero-latency processor load path.
  always_comb begin
    d_out = '0;
    if (rd_en) begin
      case (addr)
        ADDR_RX_BUF:  d_out = rx_buf_q;
        ADDR_RX_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, rx_full_q};
        ADDR_TX_BUF:  d_out = tx_buf_q;
        ADDR_TX_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, tx_full_q};
        default:      d_out = '0;
      endcase
    end
  end

  // Next state: rx clear and rx fill are mutually exclusive on rx_full_q, same for tx.
  always_comb begin
    rx_buf_d  = rx_buf_q;
    rx_full_d = rx_full_q;
    tx_buf_d  = tx_buf_q;
    tx_full_d = tx_full_q;

    if (rx_full_q) begin
      if (rd_en && (addr == ADDR_RX_BUF)) begin
        rx_full_d = 1'b0;
      end
    end else if (net_si) begin
      rx_buf_d  = net_di;
      rx_full_d = 1'b1;
    end

    if (tx_full_q) begin
      if (net_so) begin
        tx_full_d = 1'b0;
      end
    end else if (wr_en && (addr == ADDR_TX_BUF)) begin
      tx_buf_d  = d_in;
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      rx_buf_q  <= '0;
      rx_full_q <= 1'b0;
      tx_buf_q  <= '0;
      tx_full_q <= 1'b0;
    end else begin
      rx_buf_q  <= rx_buf_d;
      rx_full_q <= rx_full_d;
      tx_buf_q  <= tx_buf_d;
      tx_full_q <= tx_full_d;
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Self-checking bench for cardinal_nic: directed scenarios, then random traffic
// compared against a behavioural register model.
module tb_cardinal_nic;

  logic        Clock;
  logic        Reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_polarity;

  int checks;
  int errors;

  cardinal_nic #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
    .Clock(Clock), .Reset(Reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic idle_inputs();
    nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'b00; d_in = '0;
    net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic proc_rd(input logic [1:0] a);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a; d_in = '0;
  endtask

  task automatic proc_wr(input logic [1:0] a, input logic [63:0] d);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1'b0;
    net_si = 1'b1; net_di = 64'hAAAA;
    proc_wr(2'b10, 64'h1234);
    net_ro = 1'b1;
    tick(); tick();
    Reset = 1'b1;
    idle_inputs();
    @(negedge Clock);
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL reset_net_ri: got %b expected 1", net_ri); end
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL reset_net_so: got %b expected 0", net_so); end
    checks++; if (net_do !== 64'd0) begin errors++; $display("FAIL reset_net_do: got %h expected 0", net_do); end
    checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL reset_d_out_idle: got %h expected 0", d_out); end
    tick();
    proc_rd(2'b01);
    @(negedge Clock);
    checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL reset_rx_status: got %h expected 0", d_out); end
    tick();
    proc_rd(2'b11);
    @(negedge Clock);
    checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL reset_tx_status: got %h expected 0", d_out); end
    tick();
    idle_inputs();
  endtask

  task automatic test_rx_basic();
    net_si = 1'b1; net_di = 64'h0123_4567_89AB_CDEF;
    @(negedge Clock);
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL rx_ready_empty: got %b expected 1", net_ri); end
    tick();
    net_si = 1'b0; net_di = '0;
    proc_rd(2'b01);
    @(negedge Clock);
    checks++; if (d_out !== 64'd1) begin errors++; $display("FAIL rx_status_full: got %h expected 1", d_out); end
    checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL rx_ready_full: got %b expected 0", net_ri); end
    tick();
    proc_rd(2'b00);
    @(negedge Clock);
    checks++; if (d_out !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL rx_read_data: got %h expected %h", d_out, 64'h0123_4567_89AB_CDEF); end
    checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL rx_ready_during_read: got %b expected 0", net_ri); end
    tick();
    proc_rd(2'b01);
    @(negedge Clock);
    checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL rx_status_cleared: got %h expected 0", d_out); end
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL rx_ready_cleared: got %b expected 1", net_ri); end
    tick();
    idle_inputs();
  endtask

  task automatic test_rx_hold();
    net_si = 1'b1; net_di = 64'hDEAD_BEEF_0000_0001;
    tick();
    net_di = 64'h5;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL rx_hold_ready[%0d]: got %b expected 0", i, net_ri); end
      tick();
    end
    proc_rd(2'b00);
    @(negedge Clock);
    checks++; if (d_out !== 64'hDEAD_BEEF_0000_0001) begin errors++; $display("FAIL rx_hold_no_overwrite: got %h expected %h", d_out, 64'hDEAD_BEEF_0000_0001); end
    tick();
    nicEn = 1'b0;
    @(negedge Clock);
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL rx_hold_ready_rise: got %b expected 1", net_ri); end
    tick();
    net_si = 1'b0; net_di = '0;
    proc_rd(2'b00);
    @(negedge Clock);
    checks++; if (d_out !== 64'h5) begin errors++; $display("FAIL rx_hold_second_pkt: got %h expected 5", d_out); end
    tick();
    idle_inputs();
  endtask

  task automatic test_tx_polarity();
    proc_wr(2'b10, 64'h8000_0000_0000_0042);
    tick();
    nicEn = 1'b0; nicWrEn = 1'b0;
    net_ro = 1'b1; net_polarity = 1'b0;
    @(negedge Clock);
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL tx_wrong_polarity: got %b expected 0", net_so); end
    tick();
    net_polarity = 1'b1;
    @(negedge Clock);
    checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL tx_send_pulse: got %b expected 1", net_so); end
    checks++; if (net_do !== 64'h8000_0000_0000_0042) begin errors++; $display("FAIL tx_send_data: got %h expected %h", net_do, 64'h8000_0000_0000_0042); end
    tick();
    net_polarity = 1'b0;
    proc_rd(2'b11);
    @(negedge Clock);
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL tx_single_pulse: got %b expected 0", net_so); end
    checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL tx_status_after_send: got %h expected 0", d_out); end
    tick();
    net_polarity = 1'b1;
    @(negedge Clock);
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL tx_no_resend: got %b expected 0", net_so); end
    tick();
    idle_inputs();
  endtask

  task automatic test_tx_blocked();
    proc_wr(2'b10, 64'h11);
    tick();
    proc_rd(2'b11);
    @(negedge Clock);
    checks++; if (d_out !== 64'd1) begin errors++; $display("FAIL tx_blocked_status: got %h expected 1", d_out); end
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL tx_blocked_so: got %b expected 0", net_so); end
    tick();
    proc_wr(2'b10, 64'h22);
    tick();
    proc_rd(2'b10);
    @(negedge Clock);
    checks++; if (d_out !== 64'h11) begin errors++; $display("FAIL tx_drop_second_write: got %h expected 11", d_out); end
    tick();
    nicEn = 1'b0;
    net_ro = 1'b1; net_polarity = 1'b0;
    @(negedge Clock);
    checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL tx_release_so: got %b expected 1", net_so); end
    checks++; if (net_do !== 64'h11) begin errors++; $display("FAIL tx_release_data: got %h expected 11", net_do); end
    tick();
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    net_si = 1'b1; net_di = 64'hCAFE;
    proc_wr(2'b10, 64'h33);
    tick();
    net_si = 1'b0;
    // rx clear and tx drain in the same cycle
    proc_rd(2'b00);
    net_ro = 1'b1; net_polarity = 1'b0;
    @(negedge Clock);
    checks++; if (d_out !== 64'hCAFE) begin errors++; $display("FAIL sim_rx_read: got %h expected cafe", d_out); end
    checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL sim_tx_drain: got %b expected 1", net_so); end
    tick();
    net_ro = 1'b0;
    proc_wr(2'b10, 64'h44);
    tick();
    // write lands while tx_full=1 and the send completes: dropped
    proc_wr(2'b10, 64'h55);
    net_ro = 1'b1;
    @(negedge Clock);
    checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL sim_drain_with_write: got %b expected 1", net_so); end
    tick();
    net_ro = 1'b0;
    proc_rd(2'b11);
    @(negedge Clock);
    checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL sim_tx_status: got %h expected 0", d_out); end
    tick();
    proc_rd(2'b01);
    @(negedge Clock);
    checks++; if (d_out !== 64'd0) begin errors++; $display("FAIL sim_rx_status: got %h expected 0", d_out); end
    tick();
    proc_rd(2'b10);
    @(negedge Clock);
    checks++; if (d_out !== 64'h44) begin errors++; $display("FAIL sim_write_dropped: got %h expected 44", d_out); end
    tick();
    proc_wr(2'b10, 64'h66);
    tick();
    proc_rd(2'b10);
    @(negedge Clock);
    checks++; if (d_out !== 64'h66) begin errors++; $display("FAIL sim_next_write: got %h expected 66", d_out); end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    logic [63:0] m_rx_buf, m_tx_buf, exp_dout;
    logic        m_rx_full, m_tx_full, exp_so;
    Reset = 1'b0;
    idle_inputs();
    tick();
    Reset = 1'b1;
    m_rx_buf = '0; m_tx_buf = '0; m_rx_full = 1'b0; m_tx_full = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      Reset        = ($urandom_range(0, 59) != 0);
      nicEn        = ($urandom_range(0, 9) < 6);
      nicWrEn      = $urandom_range(0, 1) == 1;
      addr         = 2'($urandom_range(0, 3));
      d_in         = {$urandom, $urandom};
      net_si       = $urandom_range(0, 1) == 1;
      net_di       = {$urandom, $urandom};
      net_ro       = ($urandom_range(0, 3) != 0);
      net_polarity = $urandom_range(0, 1) == 1;
      @(negedge Clock);
      exp_so = m_tx_full && net_ro && (m_tx_buf[63] == net_polarity);
      exp_dout = 64'd0;
      if (nicEn && !nicWrEn) begin
        if (addr == 2'b00)      exp_dout = m_rx_buf;
        else if (addr == 2'b01) exp_dout = m_rx_full ? 64'd1 : 64'd0;
        else if (addr == 2'b10) exp_dout = m_tx_buf;
        else                    exp_dout = m_tx_full ? 64'd1 : 64'd0;
      end
      checks++; if (d_out !== exp_dout) begin errors++; $display("FAIL rand_d_out cyc %0d: got %h expected %h", cyc, d_out, exp_dout); end
      checks++; if (net_ri !== !m_rx_full) begin errors++; $display("FAIL rand_net_ri cyc %0d: got %b expected %b", cyc, net_ri, !m_rx_full); end
      checks++; if (net_so !== exp_so) begin errors++; $display("FAIL rand_net_so cyc %0d: got %b expected %b", cyc, net_so, exp_so); end
      checks++; if (net_do !== m_tx_buf) begin errors++; $display("FAIL rand_net_do cyc %0d: got %h expected %h", cyc, net_do, m_tx_buf); end
      tick();
      if (!Reset) begin
        m_rx_buf = '0; m_tx_buf = '0; m_rx_full = 1'b0; m_tx_full = 1'b0;
      end else begin
        if (m_rx_full && nicEn && !nicWrEn && addr == 2'b00) m_rx_full = 1'b0;
        else if (!m_rx_full && net_si) begin m_rx_buf = net_di; m_rx_full = 1'b1; end
        if (exp_so) m_tx_full = 1'b0;
        else if (!m_tx_full && nicEn && nicWrEn && addr == 2'b10) begin m_tx_buf = d_in; m_tx_full = 1'b1; end
      end
    end
    Reset = 1'b1;
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    Reset = 1'b0;
    test_reset();
    test_rx_basic();
    test_rx_hold();
    test_tx_polarity();
    test_tx_blocked();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
